me_stage_axi: RTL and testbench
===============================

Name: me_stage_axi

Overview:
- Next-generation MEM stage of the LoongArch five-stage pipeline, between EX and WB.
- Replaces the fixed-latency, word-only data SRAM access with a req/addr_ok/data_ok memory interface of arbitrary latency.
- Adds byte/half/word loads and stores with sign or zero extension, alignment-exception detection, valid/allowin pipeline handshake, flush with in-flight cancel, and a forwarding port.

Parameters:
- DEST_W, 5, register-file address width.
- EXB_W, 108, EX-to-ME bus width (localparam, derived from the field list below).
- WBB_W, 71, ME-to-WB bus width (localparam).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- me_allowin  out  1  ME accepts from EX this cycle.
- ex_to_me_bus  in  EXB_W  {pc[31:0], alu_result[31:0], rkd_value[31:0], mem_en, mem_we, mem_size[1:0], mem_sign, res_from_mem, gr_we, dest[4:0]}, MSB first.
- wb_allowin  in  1  WB accepts this cycle.
- me_valid  out  1  ME output valid to WB.
- me_to_wb_bus  out  WBB_W  {pc, final_result, gr_we_q, dest, ale}.
- flush  in  1  kill the ME instruction and any outstanding access.
- data_req  out  1  memory request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  out  4  byte enables.
- data_addr  out  32  byte address.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_ok  in  1  response (read data or write ack).
- data_rdata  in  32  read data.
- fwd_valid  out  1  ME has a pending GPR write.
- fwd_dest  out  DEST_W  destination register.
- fwd_data  out  32  final_result.
- fwd_block  out  1  load data not yet available; ID must stall.

Behaviour:
- Asynchronous reset (resetn low): state = IDLE, me_valid = 0, bus register = 0, cancel_cnt = 0, data_req = 0. All fwd_* are 0 during reset.
- Bus register load: loaded when ex_valid && me_allowin, independent of wb_allowin. me_valid is set to ex_valid on every allowin cycle.
- me_allowin = !me_valid || (ready_go && wb_allowin).
- ready_go rules:
  - No-access instructions (mem_en = 0) and ale = 1 instructions: ready_go is 1 immediately, giving 1-cycle latency.
  - Memory instructions: ready_go is 1 in the state after data_ok.
- ale rule: ale = mem_en && ((size 1 && addr[0]) || (size 2 && addr[1:0] != 0)). When ale = 1, no request is issued and gr_we_q is forced to 0.
- States (two-bit encoding):
  - IDLE: a valid mem_en && !ale instruction is present → REQ.
  - REQ: data_req = 1 and fields are held stable. addr_ok → WAIT.
  - WAIT: data_ok → DONE, capturing the extended load result.
  - DONE: ready_go = 1. Leaves when wb_allowin → IDLE, or goes directly to REQ if the newly loaded instruction is a memory access.
- Request encoding:
  - Stores: data_wstrb is 0001 << addr[1:0] for byte, 0011 << addr[1] * 2 for half, 1111 for word. data_wdata replicates the byte (×4) or half (×2).
  - Loads: data_wstrb = 0.
- Load extension: select lane by addr[1:0]; mem_sign = 1 sign-extends, 0 zero-extends.
- final_result = res_from_mem ? extended load : alu_result.
- Flush:
  - me_valid is cleared next cycle.
  - If flush arrives in REQ after addr_ok was sampled, or in WAIT, cancel_cnt increments. The next data_ok decrements it, and that data_ok is discarded with no state change.
  - cancel_cnt is 2 bits and saturates at 3 (cannot exceed one outstanding in practice).
  - While cancel_cnt != 0, no new request is issued and the stage stalls in IDLE.
  - Flush during REQ without addr_ok drops data_req next cycle, with no cancel.
- Simultaneous addr_ok and data_ok in REQ: treat as WAIT followed by data_ok → DONE in one step.
- Forwarding:
  - fwd_valid = me_valid && gr_we_q.
  - fwd_block = fwd_valid && res_from_mem && state != DONE.
- reset deasserted mid-access: the block re-enters IDLE, and memory-side responses arriving after reset are ignored.

Decomposition:
- Shared package (mycpu_defs): mem_size encodings, EX/ME/WB bus field offsets and widths, ME state enum.
- One sub-module, me_lsu_align: combinational wstrb/wdata generation plus load lane select/extension.

Test Plan:
- ALU op (mem_en = 0, alu_result = 0x1234, dest = 3), wb_allowin = 1 → me_valid one cycle later, final_result = 0x1234, no data_req.
- ld.b at addr 0x1003, mem_sign = 1, rdata = 0x80xxxxxx, addr_ok at cycle 2, data_ok at cycle 4 → final_result = 0xFFFFFF80. fwd_block is 1 until DONE.
- st.h at addr 0x2002, rkd = 0x0000ABCD → data_wstrb = 1100, data_wdata = 0xABCDABCD, data_wr = 1. gr_we_q = 0 at WB.
- ld.w at 0x3001 → ale = 1, no data_req, me_valid next cycle, gr_we_q = 0.
- flush in WAIT, then next load issued → the stale data_ok is dropped (cancel_cnt 1 → 0). The new load returns only its own rdata.
- wb_allowin = 0 for 5 cycles in DONE → me_to_wb_bus stable, me_allowin = 0. Release → the next EX instruction is accepted the same cycle.

Source files
------------

// File: rtl/me_stage_axi_pkg.sv
// Shared definitions for the MEM stage: memory access size codes, the EX->ME and
// ME->WB bus layouts (packed structs, MSB first), the ME access state encoding and
// the misaligned-access test used on both the incoming and the held instruction.
package me_stage_axi_pkg;

  localparam int unsigned DEST_W = 5;
  localparam int unsigned EXB_W  = 108;
  localparam int unsigned WBB_W  = 71;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       alu_result;
    logic [31:0]       rkd_value;
    logic              mem_en;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic              mem_sign;
    logic              res_from_mem;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
  } ex_bus_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       final_result;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic              ale;
  } wb_bus_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } me_state_e;

  function automatic logic is_ale(input logic mem_en, input logic [1:0] size,
                                  input logic [1:0] addr_lo);
    return mem_en && (((size == SizeHalf) && addr_lo[0]) ||
                      ((size == SizeWord) && (addr_lo != 2'b00)));
  endfunction

endpackage

// File: rtl/me_stage_axi_if.sv
// Data-memory request/response channel between the MEM stage (master) and memory (slave).
// Request side: data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata.
// Response side: data_addr_ok (request taken), data_ok (read data or write ack), data_rdata.
interface me_stage_axi_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_ok, data_rdata
  );
endinterface

// File: rtl/me_stage_axi_lsu_align.sv
// Combinational lane logic for sub-word accesses.
// Inputs : size_i, addr_lo_i (addr[1:0]), sign_i, wdata_i (store data), rdata_i (read data).
// Outputs: wstrb_o (byte enables), wdata_o (lane-replicated store data),
//          rdata_o (selected lane, sign- or zero-extended).
module me_stage_axi_lsu_align
  import me_stage_axi_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] lane;

  always_comb begin
    // Shifting by the byte offset puts the addressed byte/half at bit 0.
    lane    = 16'(rdata_i >> {addr_lo_i, 3'b000});
    wstrb_o = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SizeByte: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & lane[7]}}, lane[7:0]};
      end
      SizeHalf: begin
        wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & lane[15]}}, lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/me_stage_axi.sv
// LoongArch MEM stage with a variable-latency req/addr_ok/data_ok data-memory port.
// Ports: clk/resetn; EX side ex_valid_i, me_allowin_o, ex_to_me_bus_i; WB side wb_allowin_i,
//        me_valid_o, me_to_wb_bus_o; flush_i; dmem (memory master); forwarding fwd_valid_o,
//        fwd_dest_o, fwd_data_o, fwd_block_o (load result not yet available).
module me_stage_axi
  import me_stage_axi_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               ex_valid_i,
  output logic               me_allowin_o,
  input  logic [EXB_W-1:0]   ex_to_me_bus_i,
  input  logic               wb_allowin_i,
  output logic               me_valid_o,
  output logic [WBB_W-1:0]   me_to_wb_bus_o,
  input  logic               flush_i,
  me_stage_axi_if.master     dmem,
  output logic               fwd_valid_o,
  output logic [DEST_W-1:0]  fwd_dest_o,
  output logic [31:0]        fwd_data_o,
  output logic               fwd_block_o
);

  me_state_e   state_q, state_d;
  logic        me_valid_q, me_valid_d;
  ex_bus_t     bus_q, ex_bus;
  logic [1:0]  cancel_q, cancel_d;
  logic [31:0] load_q, load_d;
  logic [31:0] load_ext;
  logic [3:0]  wstrb;
  logic        ale, need_mem, ready_go, accept, ex_need_mem, gr_we_eff;
  wb_bus_t     wb;

  assign ex_bus      = ex_bus_t'(ex_to_me_bus_i);
  assign ale         = is_ale(bus_q.mem_en, bus_q.mem_size, bus_q.alu_result[1:0]);
  assign need_mem    = me_valid_q && bus_q.mem_en && !ale;
  assign ready_go    = !need_mem || (state_q == StDone);
  assign me_allowin_o = !me_valid_q || (ready_go && wb_allowin_i);
  assign accept      = ex_valid_i && me_allowin_o;
  assign ex_need_mem = ex_bus.mem_en &&
                       !is_ale(ex_bus.mem_en, ex_bus.mem_size, ex_bus.alu_result[1:0]);

  me_stage_axi_lsu_align u_align (
    .size_i    (bus_q.mem_size),
    .addr_lo_i (bus_q.alu_result[1:0]),
    .sign_i    (bus_q.mem_sign),
    .wdata_i   (bus_q.rkd_value),
    .rdata_i   (dmem.data_rdata),
    .wstrb_o   (wstrb),
    .wdata_o   (dmem.data_wdata),
    .rdata_o   (load_ext)
  );

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    load_d   = load_q;
    // Responses owed to flushed accesses are swallowed; cancel_q is only nonzero in StIdle.
    if ((cancel_q != 2'd0) && dmem.data_ok) cancel_d = cancel_q - 2'd1;
    case (state_q)
      StIdle: begin
        if (need_mem && (cancel_q == 2'd0) && !flush_i) state_d = StReq;
      end
      StReq: begin
        if (flush_i) begin
          state_d = StIdle;
          // Accepted but unanswered: its data_ok is still to come.
          if (dmem.data_addr_ok && !dmem.data_ok) begin
            cancel_d = (cancel_q == 2'd3) ? cancel_q : cancel_q + 2'd1;
          end
        end else if (dmem.data_addr_ok) begin
          if (dmem.data_ok) begin
            state_d = StDone;
            load_d  = load_ext;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (flush_i) begin
          state_d = StIdle;
          if (!dmem.data_ok) cancel_d = (cancel_q == 2'd3) ? cancel_q : cancel_q + 2'd1;
        end else if (dmem.data_ok) begin
          state_d = StDone;
          load_d  = load_ext;
        end
      end
      StDone: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (wb_allowin_i) begin
          // Back-to-back memory ops skip the idle cycle.
          state_d = (accept && ex_need_mem) ? StReq : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    me_valid_d = me_valid_q;
    if (flush_i) begin
      me_valid_d = 1'b0;
    end else if (me_allowin_o) begin
      me_valid_d = ex_valid_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      me_valid_q <= 1'b0;
      bus_q      <= '0;
      cancel_q   <= 2'd0;
      load_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      me_valid_q <= me_valid_d;
      cancel_q   <= cancel_d;
      load_q     <= load_d;
      if (accept) bus_q <= ex_bus;
    end
  end

  assign dmem.data_req   = (state_q == StReq);
  assign dmem.data_wr    = bus_q.mem_we;
  assign dmem.data_size  = bus_q.mem_size;
  assign dmem.data_addr  = bus_q.alu_result;
  assign dmem.data_wstrb = bus_q.mem_we ? wstrb : 4'b0000;

  assign gr_we_eff       = bus_q.gr_we && !ale;
  assign wb.pc           = bus_q.pc;
  assign wb.final_result = bus_q.res_from_mem ? load_q : bus_q.alu_result;
  assign wb.gr_we        = gr_we_eff;
  assign wb.dest         = bus_q.dest;
  assign wb.ale          = ale;
  assign me_to_wb_bus_o  = wb;
  assign me_valid_o      = me_valid_q;

  assign fwd_valid_o = me_valid_q && gr_we_eff;
  assign fwd_dest_o  = bus_q.dest;
  assign fwd_data_o  = wb.final_result;
  assign fwd_block_o = fwd_valid_o && bus_q.res_from_mem && (state_q != StDone);

endmodule

// File: tb/tb_me_stage_axi.sv
// Directed bench for me_stage_axi: ALU pass-through, sub-word load/store, misalignment,
// flush with a cancelled response, WB back-pressure and flush before address acceptance.
module tb_me_stage_axi;
  import me_stage_axi_pkg::*;

  logic              clk = 1'b0;
  logic              resetn;
  logic              ex_valid, wb_allowin, flush;
  logic [EXB_W-1:0]  ex_bus;
  logic              me_allowin, me_valid, fwd_valid, fwd_block;
  logic [WBB_W-1:0]  wb_bus;
  logic [DEST_W-1:0] fwd_dest;
  logic [31:0]       fwd_data;
  logic [WBB_W-1:0]  exp_wb;
  int                n_vec = 0;
  int                n_err = 0;

  me_stage_axi_if dmem ();

  me_stage_axi dut (
    .clk            (clk),
    .resetn         (resetn),
    .ex_valid_i     (ex_valid),
    .me_allowin_o   (me_allowin),
    .ex_to_me_bus_i (ex_bus),
    .wb_allowin_i   (wb_allowin),
    .me_valid_o     (me_valid),
    .me_to_wb_bus_o (wb_bus),
    .flush_i        (flush),
    .dmem           (dmem),
    .fwd_valid_o    (fwd_valid),
    .fwd_dest_o     (fwd_dest),
    .fwd_data_o     (fwd_data),
    .fwd_block_o    (fwd_block)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [EXB_W-1:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [31:0] rkd, input logic en,
                                          input logic we, input logic [1:0] size,
                                          input logic sgn, input logic rfm, input logic gwe,
                                          input logic [4:0] dest);
    return {pc, alu, rkd, en, we, size, sgn, rfm, gwe, dest};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; ex_valid = 1'b0; wb_allowin = 1'b1; flush = 1'b0; ex_bus = '0;
    dmem.data_addr_ok = 1'b0; dmem.data_ok = 1'b0; dmem.data_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_valid", me_valid, 0);
    check("rst_req", dmem.data_req, 0);
    check("rst_fwd", {fwd_valid, fwd_block, fwd_dest, fwd_data}, 0);
    check("rst_allowin", me_allowin, 1);
    resetn = 1'b1;

    // ALU op, one-cycle pass-through
    @(negedge clk);
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c000000, 32'h1234, 32'h0, 0, 0, 2'd0, 0, 0, 1, 5'd3);
    #1 check("alu_allowin", me_allowin, 1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("alu_valid", me_valid, 1);
    check("alu_result", wb_bus[38:7], 32'h1234);
    check("alu_dest", wb_bus[5:1], 5'd3);
    check("alu_noreq", dmem.data_req, 0);
    check("alu_fwd", {fwd_valid, fwd_block, fwd_data}, {1'b1, 1'b0, 32'h1234});
    @(negedge clk);
    check("alu_drain", me_valid, 0);

    // ld.b 0x1003 signed, addr_ok on second REQ cycle, data_ok two cycles later
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c000004, 32'h1003, 32'h0, 1, 0, 2'd0, 1, 1, 1, 5'd4);
    @(negedge clk);
    ex_valid = 1'b0;
    check("ldb_block_c0", fwd_block, 1);
    check("ldb_req_c0", dmem.data_req, 0);
    @(negedge clk);
    check("ldb_req", {dmem.data_req, dmem.data_wr, dmem.data_size, dmem.data_wstrb},
          {1'b1, 1'b0, 2'd0, 4'b0000});
    check("ldb_addr", dmem.data_addr, 32'h1003);
    @(negedge clk);
    check("ldb_req_hold", dmem.data_req, 1);
    dmem.data_addr_ok = 1'b1;
    @(negedge clk);
    dmem.data_addr_ok = 1'b0;
    check("ldb_wait", {dmem.data_req, fwd_block, me_allowin}, {1'b0, 1'b1, 1'b0});
    @(negedge clk);
    dmem.data_ok = 1'b1; dmem.data_rdata = 32'h80123456;
    @(negedge clk);
    dmem.data_ok = 1'b0;
    check("ldb_result", wb_bus[38:7], 32'hFFFFFF80);
    check("ldb_done", {me_valid, fwd_valid, fwd_block, wb_bus[6], wb_bus[0]},
          {1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    check("ldb_drain", me_valid, 0);

    // st.h 0x2002, addr_ok and data_ok together
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c000008, 32'h2002, 32'h0000ABCD, 1, 1, 2'd1, 0, 0, 0, 5'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    check("sth_req", {dmem.data_req, dmem.data_wr, dmem.data_size, dmem.data_wstrb},
          {1'b1, 1'b1, 2'd1, 4'b1100});
    check("sth_wdata", dmem.data_wdata, 32'hABCDABCD);
    dmem.data_addr_ok = 1'b1; dmem.data_ok = 1'b1;
    @(negedge clk);
    dmem.data_addr_ok = 1'b0; dmem.data_ok = 1'b0;
    check("sth_done", {me_valid, dmem.data_req, wb_bus[6], wb_bus[0], fwd_valid},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    check("sth_drain", me_valid, 0);

    // ld.w 0x3001: misaligned
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c00000c, 32'h3001, 32'h0, 1, 0, 2'd2, 1, 1, 1, 5'd5);
    @(negedge clk);
    ex_valid = 1'b0;
    check("ale_flags", {me_valid, dmem.data_req, me_allowin, wb_bus[6], wb_bus[0], fwd_valid},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    check("ale_drain", {me_valid, dmem.data_req}, 0);

    // ld.w 0x4000 flushed in WAIT; following ld.hu 0x5002 must skip the stale response
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c000010, 32'h4000, 32'h0, 1, 0, 2'd2, 1, 1, 1, 5'd6);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    check("flw_req", dmem.data_req, 1);
    dmem.data_addr_ok = 1'b1;
    @(negedge clk);
    dmem.data_addr_ok = 1'b0;
    check("flw_wait", {dmem.data_req, fwd_block}, {1'b0, 1'b1});
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flw_flushed", {me_valid, dmem.data_req, fwd_valid}, 0);
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c000040, 32'h5002, 32'h0, 1, 0, 2'd1, 0, 1, 1, 5'd9);
    #1 check("flw_allowin", me_allowin, 1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("flw_stall", {me_valid, dmem.data_req, fwd_block}, {1'b1, 1'b0, 1'b1});
    dmem.data_ok = 1'b1; dmem.data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dmem.data_ok = 1'b0;
    check("flw_stall2", {dmem.data_req, fwd_block}, {1'b0, 1'b1});
    @(negedge clk);
    check("flw_req2", {dmem.data_req, dmem.data_size, dmem.data_wstrb}, {1'b1, 2'd1, 4'b0000});
    check("flw_addr2", dmem.data_addr, 32'h5002);
    dmem.data_addr_ok = 1'b1;
    @(negedge clk);
    dmem.data_addr_ok = 1'b0;
    dmem.data_ok = 1'b1; dmem.data_rdata = 32'h87651234;
    wb_allowin = 1'b0;

    // WB back-pressure in DONE, st.b waiting in EX
    @(negedge clk);
    dmem.data_ok = 1'b0;
    check("hld_result", wb_bus[38:7], 32'h00008765);
    exp_wb = {32'h1c000040, 32'h00008765, 1'b1, 5'd9, 1'b0};
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c000044, 32'h6001, 32'h000000A5, 1, 1, 2'd0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      #1 check("hld_bus", wb_bus, exp_wb);
      check("hld_allowin", {me_valid, me_allowin, dmem.data_req}, {1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    wb_allowin = 1'b1;
    #1 check("rel_allowin", me_allowin, 1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("stb_req", {me_valid, dmem.data_req, dmem.data_wr, dmem.data_size, dmem.data_wstrb},
          {1'b1, 1'b1, 1'b1, 2'd0, 4'b0010});
    check("stb_wdata", dmem.data_wdata, 32'hA5A5A5A5);
    check("stb_addr", dmem.data_addr, 32'h6001);
    dmem.data_addr_ok = 1'b1; dmem.data_ok = 1'b1;
    @(negedge clk);
    dmem.data_addr_ok = 1'b0; dmem.data_ok = 1'b0;
    check("stb_done", {me_valid, dmem.data_req, wb_bus[70:39]}, {1'b1, 1'b0, 32'h1c000044});
    @(negedge clk);
    check("stb_drain", me_valid, 0);

    // ld.w 0x7000 flushed before addr_ok: no cancel, next ld.bu issues at once
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c000048, 32'h7000, 32'h0, 1, 0, 2'd2, 1, 1, 1, 5'd8);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    check("frq_req", dmem.data_req, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("frq_dropped", {me_valid, dmem.data_req}, 0);
    ex_valid = 1'b1;
    ex_bus = mk(32'h1c00004c, 32'h7001, 32'h0, 1, 0, 2'd0, 0, 1, 1, 5'd10);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    check("frq_req2", {dmem.data_req, dmem.data_addr}, {1'b1, 32'h7001});
    dmem.data_addr_ok = 1'b1; dmem.data_ok = 1'b1; dmem.data_rdata = 32'h0000AB00;
    @(negedge clk);
    dmem.data_addr_ok = 1'b0; dmem.data_ok = 1'b0;
    check("frq_result", {me_valid, fwd_valid, fwd_dest, fwd_data},
          {1'b1, 1'b1, 5'd10, 32'h000000AB});
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
